pwm_capture: RTL



---
 rtl/pwm_capture_pkg.sv | 27 ++
 rtl/pwm_capture_sync.sv | 56 +++++
 rtl/pwm_capture.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: register map, control and
// status bit positions, FSM state encoding and the default counter width.
package pwm_capture_pkg;

  localparam int unsigned CNT_BITS_DEF = 16;

  localparam logic [7:0] ADDR_CTL0    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h01;
  localparam logic [7:0] ADDR_PER_HI  = 8'h02;
  localparam logic [7:0] ADDR_PER_LO  = 8'h03;
  localparam logic [7:0] ADDR_HIGH_HI = 8'h04;
  localparam logic [7:0] ADDR_HIGH_LO = 8'h05;

  localparam int unsigned CTL_ENABLE_BIT = 7;
  localparam int unsigned CTL_HOLD_BIT   = 6;

  localparam int unsigned ST_VALID_BIT = 0;
  localparam int unsigned ST_OVF_BIT   = 1;
  localparam int unsigned ST_NEW_BIT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_capture_sync.sv
// Input conditioning for pwm_capture: 2-flop synchronizer, optional glitch
// filter and edge detect.
//   clk, rst_n : clock, asynchronous active-low reset
//   pwm        : asynchronous PWM input
//   rise, fall : single-cycle edge strobes of the conditioned level
// Macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample agreement filter
// (2 cycles extra latency on both edges, pulses < 3 cycles rejected).
module pwm_capture_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm,
  output logic rise,
  output logic fall
);

  logic s1, s2;
  logic lvl, lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm;
      s2 <= s1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= '0;
    else        hist <= {hist[0], s2};
  end

  // s2 plus two history samples form the 3-sample window; lvl_d doubles as
  // the held filter state, so the edge detector sees a combinational level.
  always_comb begin
    lvl = lvl_d;
    if (s2 && (hist == 2'b11))       lvl = 1'b1;
    else if (!s2 && (hist == 2'b00)) lvl = 1'b0;
  end
`else
  always_comb lvl = s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_d <= 1'b0;
    else        lvl_d <= lvl;
  end

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/pwm_capture.sv
// Register-mapped PWM input decoder: measures period and high time of pwm_i
// in clk_i cycles and exposes them on an 8-bit register bus.
//   clk_i, nrst_i : clock, asynchronous active-low reset
//   b_addr_i, b_data_i, b_write_i : register write bus
//   b_data_o      : combinational read data (unmapped reads 0x00)
//   pwm_i         : asynchronous PWM input
//   new_o         : level copy of status.new
// Macro PWM_CAPTURE_GLITCH_FILTER_EN enables the input glitch filter.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_BITS = CNT_BITS_DEF
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic [7:0] b_addr_i,
  input  logic [7:0] b_data_i,
  input  logic       b_write_i,
  output logic [7:0] b_data_o,
  input  logic       pwm_i,
  output logic       new_o
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic [7:0]          ctl0;
  logic                st_valid, st_ovf, st_new;
  logic [CNT_BITS-1:0] period_q, high_q, per_cnt, high_pend;
  logic                rise, fall;
  logic                enable, hold;
  logic                commit, timeout, cnt_start, pend_load;
  logic                wr_ctl, wr_stat, publish;
  logic [15:0]         per16, high16;
  state_t              state, state_nxt;

  pwm_capture_sync u_sync (
    .clk   (clk_i),
    .rst_n (nrst_i),
    .pwm   (pwm_i),
    .rise  (rise),
    .fall  (fall)
  );

  assign enable  = ctl0[CTL_ENABLE_BIT];
  assign hold    = ctl0[CTL_HOLD_BIT];
  assign wr_ctl  = b_write_i && (b_addr_i == ADDR_CTL0);
  assign wr_stat = b_write_i && (b_addr_i == ADDR_STATUS);
  assign publish = commit && !hold;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    timeout   = 1'b0;
    cnt_start = 1'b0;
    pend_load = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_nxt = ST_HIGH;
            cnt_start = 1'b1;
          end
        end
        ST_HIGH: begin
          if (per_cnt == CNT_MAX) begin
            timeout   = 1'b1;
            state_nxt = ST_IDLE;
          end else if (fall) begin
            pend_load = 1'b1;
            state_nxt = ST_LOW;
          end
        end
        ST_LOW: begin
          if (per_cnt == CNT_MAX) begin
            timeout   = 1'b1;
            state_nxt = ST_IDLE;
          end else if (rise) begin
            commit    = 1'b1;
            cnt_start = 1'b1;
            state_nxt = ST_HIGH;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // per_cnt restarts at 1 on each rise, so at the next rise it equals the
  // period in cycles; it idles at 0 whenever the FSM heads back to IDLE.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      per_cnt   <= '0;
      high_pend <= '0;
    end else begin
      if (cnt_start)                  per_cnt <= CNT_ONE;
      else if (state_nxt == ST_IDLE)  per_cnt <= '0;
      else                            per_cnt <= per_cnt + CNT_ONE;
      if (pend_load) high_pend <= per_cnt;
    end
  end

  // Status flags: write-1-to-clear, with a same-cycle set taking priority.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ctl0     <= '0;
      st_valid <= 1'b0;
      st_ovf   <= 1'b0;
      st_new   <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
    end else begin
      if (wr_ctl) ctl0 <= b_data_i;
      st_valid <= (st_valid & ~(wr_stat & b_data_i[ST_VALID_BIT])) | publish;
      st_ovf   <= (st_ovf   & ~(wr_stat & b_data_i[ST_OVF_BIT]))   | timeout;
      st_new   <= (st_new   & ~(wr_stat & b_data_i[ST_NEW_BIT]))   | publish;
      if (publish) begin
        period_q <= per_cnt;
        high_q   <= high_pend;
      end
    end
  end

  assign per16  = 16'(period_q);
  assign high16 = 16'(high_q);

  always_comb begin
    b_data_o = '0;
    case (b_addr_i)
      ADDR_CTL0:    b_data_o = ctl0;
      ADDR_STATUS:  b_data_o = {5'b0, st_new, st_ovf, st_valid};
      ADDR_PER_HI:  b_data_o = per16[15:8];
      ADDR_PER_LO:  b_data_o = per16[7:0];
      ADDR_HIGH_HI: b_data_o = high16[15:8];
      ADDR_HIGH_LO: b_data_o = high16[7:0];
      default:      b_data_o = '0;
    endcase
  end

  assign new_o = st_new;

endmodule
